// File: rtl/riscv_pkg.sv
// Shared RV32/RV64 decode types: operation classes, opcodes, immediate formats
// and the XLEN-independent part of a decoded instruction entry.
package riscv_pkg;

  localparam int unsigned ILEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    OP_ILLEGAL  = 4'd0,
    OP_LUI      = 4'd1,
    OP_AUIPC    = 4'd2,
    OP_JAL      = 4'd3,
    OP_JALR     = 4'd4,
    OP_BRANCH   = 4'd5,
    OP_LOAD     = 4'd6,
    OP_STORE    = 4'd7,
    OP_OP_IMM   = 4'd8,
    OP_OP       = 4'd9,
    OP_MISC_MEM = 4'd10,
    OP_SYSTEM   = 4'd11
  } t_risc_v_op;

  typedef enum logic [2:0] {
    IMM_ZERO = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } t_imm_fmt;

  typedef struct packed {
    t_risc_v_op        op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              illegal;
  } t_dec_entry;

  function automatic logic [ILEN-1:0] bswap32(input logic [ILEN-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and decode-side handshake bundle of the decode stage.
interface decode_stage_if import riscv_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PCW  = 32
) ();

  logic                in_valid_i;
  logic                in_ready_o;
  logic [ILEN-1:0]     in_data_i;
  logic [PCW-1:0]      in_pc_i;

  logic                out_valid_o;
  logic                out_ready_i;
  t_risc_v_op          out_op_o;
  logic [REG_W-1:0]    out_rd_o;
  logic [REG_W-1:0]    out_rs1_o;
  logic [REG_W-1:0]    out_rs2_o;
  logic [2:0]          out_funct3_o;
  logic [6:0]          out_funct7_o;
  logic [XLEN-1:0]     out_imm_o;
  logic [PCW-1:0]      out_pc_o;
  logic                out_illegal_o;

  modport master (
    output in_valid_i, in_data_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_op_o, out_rd_o, out_rs1_o, out_rs2_o,
           out_funct3_o, out_funct7_o, out_imm_o, out_pc_o, out_illegal_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_op_o, out_rd_o, out_rs1_o, out_rs2_o,
           out_funct3_o, out_funct7_o, out_imm_o, out_pc_o, out_illegal_o
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational instruction decode: op class, register/function fields,
// illegal detection and sign-extended immediate.
module imm_gen import riscv_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [ILEN-1:0] instr_i,
  output t_dec_entry      entry_c,
  output logic [XLEN-1:0] imm_c
);

  t_risc_v_op      op;
  t_imm_fmt        fmt;
  logic            illegal;
  logic [ILEN-1:0] imm32;

  always_comb begin
    op      = OP_ILLEGAL;
    fmt     = IMM_ZERO;
    illegal = 1'b0;
    imm32   = '0;
    entry_c = '0;

    case (instr_i[6:0])
      OPC_LUI:      begin op = OP_LUI;      fmt = IMM_U; end
      OPC_AUIPC:    begin op = OP_AUIPC;    fmt = IMM_U; end
      OPC_JAL:      begin op = OP_JAL;      fmt = IMM_J; end
      OPC_JALR:     begin op = OP_JALR;     fmt = IMM_I; end
      OPC_BRANCH:   begin op = OP_BRANCH;   fmt = IMM_B; end
      OPC_LOAD:     begin op = OP_LOAD;     fmt = IMM_I; end
      OPC_STORE:    begin op = OP_STORE;    fmt = IMM_S; end
      OPC_OP_IMM:   begin op = OP_OP_IMM;   fmt = IMM_I; end
      OPC_OP:       begin op = OP_OP;       fmt = IMM_ZERO; end
      OPC_MISC_MEM: begin op = OP_MISC_MEM; fmt = IMM_I; end
      OPC_SYSTEM:   begin op = OP_SYSTEM;   fmt = IMM_I; end
      default:      ;
    endcase

    illegal = (instr_i[1:0] != 2'b11) || (op == OP_ILLEGAL) ||
              ((op == OP_JALR) && (instr_i[14:12] != 3'b000));
    if (illegal) begin
      op  = OP_ILLEGAL;
      fmt = IMM_ZERO;
    end

    case (fmt)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    // Raw field slices are kept even for illegal encodings.
    entry_c.op      = op;
    entry_c.rd      = instr_i[11:7];
    entry_c.rs1     = instr_i[19:15];
    entry_c.rs2     = instr_i[24:20];
    entry_c.funct3  = instr_i[14:12];
    entry_c.funct7  = instr_i[31:25];
    entry_c.illegal = illegal;
  end

  assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: byte-orders and decodes fetched words, buffering up to two
// decoded entries in an in-order FIFO with valid/ready handshakes.
module decode_stage import riscv_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter bit          BSWAP = 1'b1,
  parameter int unsigned PCW   = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  decode_stage_if.slave bus
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [ILEN-1:0] instr_c;
  t_dec_entry      dec_c;
  logic [XLEN-1:0] imm_c;

  t_dec_entry      entry_q [DEPTH];
  t_dec_entry      entry_d [DEPTH];
  logic [XLEN-1:0] imm_q   [DEPTH];
  logic [XLEN-1:0] imm_d   [DEPTH];
  logic [PCW-1:0]  pc_q    [DEPTH];
  logic [PCW-1:0]  pc_d    [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic push_c, pop_c, wr_idx_c;

  assign instr_c = BSWAP ? bswap32(bus.in_data_i) : bus.in_data_i;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (instr_c),
    .entry_c (dec_c),
    .imm_c   (imm_c)
  );

  assign bus.in_ready_o  = (count_q < CNT_W'(DEPTH));
  assign bus.out_valid_o = (count_q != '0);

  assign push_c   = bus.in_valid_i && bus.in_ready_o && !flush_i;
  assign pop_c    = bus.out_valid_o && bus.out_ready_i;
  // Slot 0 is always the head; a push lands in slot 1 only if slot 0 stays put.
  assign wr_idx_c = (count_q == CNT_W'(1)) && !pop_c;

  always_comb begin
    entry_d = entry_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    count_d = count_q;

    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_c) begin
        entry_d[0] = entry_q[1];
        imm_d[0]   = imm_q[1];
        pc_d[0]    = pc_q[1];
      end
      if (push_c) begin
        entry_d[wr_idx_c] = dec_c;
        imm_d[wr_idx_c]   = imm_c;
        pc_d[wr_idx_c]    = bus.in_pc_i;
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        imm_q[i]   <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      entry_q <= entry_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.out_op_o      = entry_q[0].op;
  assign bus.out_rd_o      = entry_q[0].rd;
  assign bus.out_rs1_o     = entry_q[0].rs1;
  assign bus.out_rs2_o     = entry_q[0].rs2;
  assign bus.out_funct3_o  = entry_q[0].funct3;
  assign bus.out_funct7_o  = entry_q[0].funct7;
  assign bus.out_illegal_o = entry_q[0].illegal;
  assign bus.out_imm_o     = imm_q[0];
  assign bus.out_pc_o      = pc_q[0];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: three instances (BSWAP=1/XLEN=32,
// BSWAP=0/XLEN=32, BSWAP=0/XLEN=64) share one stimulus stream.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data, in_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PCW(32)) if_a ();
  decode_stage_if #(.XLEN(32), .PCW(32)) if_b ();
  decode_stage_if #(.XLEN(64), .PCW(32)) if_c ();

  assign if_a.in_valid_i  = in_valid;
  assign if_a.in_data_i   = in_data;
  assign if_a.in_pc_i     = in_pc;
  assign if_a.out_ready_i = out_ready;
  assign if_b.in_valid_i  = in_valid;
  assign if_b.in_data_i   = in_data;
  assign if_b.in_pc_i     = in_pc;
  assign if_b.out_ready_i = out_ready;
  assign if_c.in_valid_i  = in_valid;
  assign if_c.in_data_i   = in_data;
  assign if_c.in_pc_i     = in_pc;
  assign if_c.out_ready_i = out_ready;

  decode_stage #(.XLEN(32), .BSWAP(1'b1), .PCW(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_a));
  decode_stage #(.XLEN(32), .BSWAP(1'b0), .PCW(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_b));
  decode_stage #(.XLEN(64), .BSWAP(1'b0), .PCW(32)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word with the consumer ready; entry is at head afterwards.
  task automatic issue(input logic [31:0] d, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_data   = d;
    in_pc     = pc;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_pc = '0;
    tick(); tick();

    chk("rst_valid",   64'(if_a.out_valid_o),   64'd0);
    chk("rst_ready",   64'(if_a.in_ready_o),    64'd1);
    chk("rst_op",      64'(if_a.out_op_o),      64'(OP_ILLEGAL));
    chk("rst_illegal", 64'(if_a.out_illegal_o), 64'd0);
    chk("rst_imm",     64'(if_c.out_imm_o),     64'd0);
    chk("rst_pc",      64'(if_a.out_pc_o),      64'd0);
    rst = 1'b0;

    // addi x1,x0,-1 stored little-endian
    in_valid = 1'b1; in_data = 32'h9300F0FF; in_pc = 32'h100; out_ready = 1'b0;
    chk("addi_pre_valid", 64'(if_a.out_valid_o), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 64'(if_a.out_valid_o), 64'd1);
    chk("addi_op",    64'(if_a.out_op_o),    64'(OP_OP_IMM));
    chk("addi_rd",    64'(if_a.out_rd_o),    64'd1);
    chk("addi_rs1",   64'(if_a.out_rs1_o),   64'd0);
    chk("addi_imm",   64'(if_a.out_imm_o),   64'hFFFF_FFFF);
    chk("addi_pc",    64'(if_a.out_pc_o),    64'h100);
    chk("addi_ill",   64'(if_a.out_illegal_o), 64'd0);
    chk("raw7f_ill",  64'(if_b.out_illegal_o), 64'd1);
    chk("raw7f_imm",  64'(if_b.out_imm_o),     64'd0);
    out_ready = 1'b1;
    tick();
    chk("addi_popped", 64'(if_a.out_valid_o), 64'd0);

    issue(32'hFE000EE3, 32'h104);
    chk("beq_op",    64'(if_b.out_op_o),  64'(OP_BRANCH));
    chk("beq_imm32", 64'(if_b.out_imm_o), 64'hFFFF_FFFC);
    chk("beq_imm64", 64'(if_c.out_imm_o), 64'hFFFF_FFFF_FFFF_FFFC);
    tick();

    issue(32'h123452B7, 32'h108);
    chk("lui_op",    64'(if_b.out_op_o),  64'(OP_LUI));
    chk("lui_rd",    64'(if_b.out_rd_o),  64'd5);
    chk("lui_imm",   64'(if_b.out_imm_o), 64'h1234_5000);
    chk("lui_imm64", 64'(if_c.out_imm_o), 64'h0000_0000_1234_5000);
    tick();

    issue(32'h0000_0000, 32'h10C);
    chk("zero_ill", 64'(if_b.out_illegal_o), 64'd1);
    chk("zero_op",  64'(if_b.out_op_o),      64'(OP_ILLEGAL));
    chk("zero_imm", 64'(if_b.out_imm_o),     64'd0);
    tick();

    issue(32'h800000B7, 32'h110);
    chk("luineg_imm32", 64'(if_b.out_imm_o), 64'h8000_0000);
    chk("luineg_imm64", 64'(if_c.out_imm_o), 64'hFFFF_FFFF_8000_0000);
    tick();

    issue(32'h000010E7, 32'h114);
    chk("jalr_f3_ill", 64'(if_b.out_illegal_o), 64'd1);
    chk("jalr_f3_rd",  64'(if_b.out_rd_o),      64'd1);
    chk("jalr_f3_imm", 64'(if_b.out_imm_o),     64'd0);
    tick();

    issue(32'hFE20AE23, 32'h118);
    chk("sw_op",  64'(if_b.out_op_o),     64'(OP_STORE));
    chk("sw_imm", 64'(if_b.out_imm_o),    64'hFFFF_FFFC);
    chk("sw_rs1", 64'(if_b.out_rs1_o),    64'd1);
    chk("sw_rs2", 64'(if_b.out_rs2_o),    64'd2);
    chk("sw_f3",  64'(if_b.out_funct3_o), 64'd2);
    tick();

    issue(32'h008000EF, 32'h11C);
    chk("jal_op",  64'(if_b.out_op_o),  64'(OP_JAL));
    chk("jal_imm", 64'(if_b.out_imm_o), 64'd8);
    chk("jal_rd",  64'(if_b.out_rd_o),  64'd1);
    tick();

    // backpressure: three words, only two fit
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h000000B7; in_pc = 32'h200; tick();
    in_data = 32'h00000137; in_pc = 32'h204; tick();
    chk("bp_full_ready", 64'(if_b.in_ready_o),  64'd0);
    chk("bp_full_valid", 64'(if_b.out_valid_o), 64'd1);
    in_data = 32'h000001B7; in_pc = 32'h208; tick();
    chk("bp_hold_rd",    64'(if_b.out_rd_o),    64'd1);
    chk("bp_hold_pc",    64'(if_b.out_pc_o),    64'h200);
    chk("bp_hold_ready", 64'(if_b.in_ready_o),  64'd0);
    out_ready = 1'b1; tick();
    chk("bp_pop1_rd",    64'(if_b.out_rd_o),    64'd2);
    chk("bp_pop1_pc",    64'(if_b.out_pc_o),    64'h204);
    chk("bp_pop1_ready", 64'(if_b.in_ready_o),  64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop2_rd",    64'(if_b.out_rd_o),    64'd3);
    chk("bp_pop2_pc",    64'(if_b.out_pc_o),    64'h208);
    tick();
    chk("bp_drained",    64'(if_b.out_valid_o), 64'd0);

    // flush at occupancy 2 with a word presented
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h00000237; in_pc = 32'h300; tick();
    in_data = 32'h000002B7; in_pc = 32'h304; tick();
    chk("fl2_valid", 64'(if_b.out_valid_o), 64'd1);
    flush = 1'b1; in_data = 32'h00000337; in_pc = 32'h308;
    chk("fl2_ready_in_flush", 64'(if_b.in_ready_o), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid_after", 64'(if_b.out_valid_o), 64'd0);
    chk("fl2_ready_after", 64'(if_b.in_ready_o),  64'd1);
    out_ready = 1'b1; tick();
    chk("fl2_no_ghost", 64'(if_b.out_valid_o), 64'd0);

    // flush at occupancy 1: presented word would otherwise be accepted
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h000003B7; in_pc = 32'h30C; tick();
    flush = 1'b1; in_data = 32'h00000437; in_pc = 32'h310;
    chk("fl1_ready_in_flush", 64'(if_b.in_ready_o), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_valid_after", 64'(if_b.out_valid_o), 64'd0);
    tick();
    chk("fl1_no_ghost", 64'(if_b.out_valid_o), 64'd0);

    // asynchronous reset between edges at occupancy 1
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h000004B7; in_pc = 32'h400; tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", 64'(if_b.out_valid_o), 64'd1);
    #2; rst = 1'b1; #1;
    chk("ar_valid", 64'(if_b.out_valid_o), 64'd0);
    chk("ar_ready", 64'(if_b.in_ready_o),  64'd1);
    chk("ar_rd",    64'(if_b.out_rd_o),    64'd0);
    chk("ar_pc",    64'(if_b.out_pc_o),    64'd0);
    tick();
    rst = 1'b0;
    issue(32'h00000537, 32'h404);
    chk("ar_first_valid", 64'(if_b.out_valid_o), 64'd1);
    chk("ar_first_rd",    64'(if_b.out_rd_o),    64'd10);
    chk("ar_first_pc",    64'(if_b.out_pc_o),    64'h404);
    tick();
    chk("ar_first_drained", 64'(if_b.out_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
